// File: rtl/bsg_dff_share_pkg.sv
// ----------------------------------------------------------------------------
// bsg_dff_share_pkg
//
// Purpose:
//   Shared constants, helpers and types for the bsg_dff_share_rr block: a
//   single output register stage shared round-robin among several requesters.
//
// Contents:
//   default_width_lp  default data word width in bits
//   default_els_lp    default number of requesters
//   lg_els()          index width for a given requester count (1 for a
//                     single requester, so index vectors never collapse to
//                     zero width)
//   grant_idx_t       grant index type for the default configuration
//
// Configuration macro used by the block: BSG_DFF_SHARE_TAG_EN
// ----------------------------------------------------------------------------
package bsg_dff_share_pkg;

  localparam int default_width_lp = 16;
  localparam int default_els_lp   = 4;

  // Width of a requester index. A single requester still gets a one-bit
  // index so ports and registers keep a legal width.
  function automatic int lg_els(input int els);
    return (els <= 1) ? 1 : $clog2(els);
  endfunction

  typedef logic [lg_els(default_els_lp)-1:0] grant_idx_t;

endpackage

// File: rtl/bsg_dff_share_rr_if.sv
// ----------------------------------------------------------------------------
// bsg_dff_share_rr_if
//
// Purpose:
//   Bundles the requester-side and consumer-side handshakes of the shared
//   output register.
//
// Signals (named from the point of view of the shared register):
//   v_i     [els_p]          per-requester valid
//   data_i  [els_p*width_p]  requester r word at [r*width_p +: width_p]
//   yumi_o  [els_p]          one-hot; word from requester r captured this cycle
//   v_o                      output register holds a valid word
//   data_o  [width_p]        output register contents
//   yumi_i                   consumer takes data_o this cycle
//   tag_o   [lg(els_p)]      source requester of data_o (BSG_DFF_SHARE_TAG_EN)
//
// Modports:
//   slave   the shared register itself
//   master  the environment (requesters plus consumer)
// ----------------------------------------------------------------------------
interface bsg_dff_share_rr_if
  import bsg_dff_share_pkg::*;
#(
  parameter int width_p = default_width_lp,
  parameter int els_p   = default_els_lp
);

  logic [els_p-1:0]         v_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         yumi_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;
`ifdef BSG_DFF_SHARE_TAG_EN
  logic [lg_els(els_p)-1:0] tag_o;
`endif

  modport slave (
    input  v_i,
    input  data_i,
    input  yumi_i,
    output yumi_o,
    output v_o,
`ifdef BSG_DFF_SHARE_TAG_EN
    output tag_o,
`endif
    output data_o
  );

  modport master (
    output v_i,
    output data_i,
    output yumi_i,
    input  yumi_o,
    input  v_o,
`ifdef BSG_DFF_SHARE_TAG_EN
    input  tag_o,
`endif
    input  data_o
  );

endinterface

// File: rtl/bsg_dff_share_rr_arb.sv
// ----------------------------------------------------------------------------
// bsg_dff_share_rr_arb
//
// Purpose:
//   Round-robin arbiter for the shared output register. Holds the last-grant
//   pointer and picks the first valid requester after it, wrapping around.
//
// Ports:
//   clk_i    clock
//   reset_i  asynchronous active-high reset; also suppresses any grant
//   v_i      per-requester valid
//   space_i  the output register can accept a word this cycle
//   yumi_o   one-hot grant, zero when nothing is granted
//   grant_o  index of the granted requester (meaningful when |yumi_o)
// ----------------------------------------------------------------------------
module bsg_dff_share_rr_arb
  import bsg_dff_share_pkg::*;
#(
  parameter  int els_p     = default_els_lp,
  localparam int lg_els_lp = lg_els(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [els_p-1:0]     v_i,
  input  logic                 space_i,
  output logic [els_p-1:0]     yumi_o,
  output logic [lg_els_lp-1:0] grant_o
);

  if (els_p == 1) begin : g_single

    // With one requester there is nothing to arbitrate: grant whenever it
    // asks and the register has room.
    assign yumi_o  = v_i & {els_p{space_i & ~reset_i}};
    assign grant_o = '0;

  end else begin : g_rr

    logic [lg_els_lp-1:0] ptr_q;
    logic [lg_els_lp-1:0] ptr_d;
    logic [lg_els_lp-1:0] idx;
    logic                 found;

    // Walk the requesters starting just after the last winner and stop at
    // the first valid one. The winner is computed even without space, but
    // yumi_o is cleared then, and also while reset is held so that nothing
    // is acknowledged in a cycle whose capture would be thrown away.
    always_comb begin
      yumi_o  = '0;
      grant_o = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= els_p; k++) begin
        idx = lg_els_lp'((int'(ptr_q) + k) % els_p);
        if (!found && v_i[idx]) begin
          found       = 1'b1;
          grant_o     = idx;
          yumi_o[idx] = 1'b1;
        end
      end
      if (!space_i || reset_i) begin
        yumi_o = '0;
      end
    end

    // The pointer only moves on an actual grant, so idle cycles and
    // backpressure never disturb the rotation order.
    assign ptr_d = (|yumi_o) ? grant_o : ptr_q;

    // Reset parks the pointer on the last requester so requester 0 is the
    // first one searched.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        ptr_q <= lg_els_lp'(els_p - 1);
      end else begin
        ptr_q <= ptr_d;
      end
    end

  end

endmodule

// File: rtl/bsg_dff_share_rr.sv
// ----------------------------------------------------------------------------
// bsg_dff_share_rr
//
// Purpose:
//   One width_p-bit output register shared by els_p requesters. A round-robin
//   arbiter picks one valid requester per cycle whenever the register has
//   room, the chosen word is captured on the next edge, and the register
//   drains through a valid/yumi handshake. A grant in the same cycle as a
//   consumer yumi replaces the word with no bubble.
//
// Ports:
//   clk_i    clock, all state updates on posedge
//   reset_i  asynchronous active-high reset
//   bus_if   bsg_dff_share_rr_if.slave: v_i, data_i, yumi_o, v_o, data_o,
//            yumi_i and, with the tag option, tag_o
//
// Configuration:
//   BSG_DFF_SHARE_TAG_EN  when defined, a tag register records which
//                         requester supplied data_o and drives tag_o
// ----------------------------------------------------------------------------
module bsg_dff_share_rr
  import bsg_dff_share_pkg::*;
#(
  parameter  int width_p   = default_width_lp,
  parameter  int els_p     = default_els_lp,
  localparam int lg_els_lp = lg_els(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bsg_dff_share_rr_if.slave      bus_if
);

  logic                 v_q;
  logic                 v_d;
  logic [width_p-1:0]   data_q;
  logic [width_p-1:0]   data_d;
  logic                 deq;
  logic                 space;
  logic [els_p-1:0]     yumi;
  logic [lg_els_lp-1:0] grant;
  logic [width_p-1:0]   sel_data;

  // A consumer yumi only counts while a word is actually held; a stray yumi
  // on an empty register is ignored. The register has room when it is empty
  // or being drained this same cycle.
  assign deq   = bus_if.yumi_i & v_q;
  assign space = ~v_q | deq;

  bsg_dff_share_rr_arb #(
    .els_p   (els_p)
  ) u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (bus_if.v_i),
    .space_i (space),
    .yumi_o  (yumi),
    .grant_o (grant)
  );

  assign bus_if.yumi_o = yumi;

  // Grant is one-hot, so masking each word with its yumi bit and OR-ing
  // them together selects the winner without a wide index mux.
  always_comb begin
    sel_data = '0;
    for (int r = 0; r < els_p; r++) begin
      sel_data |= bus_if.data_i[r*width_p +: width_p] & {width_p{yumi[r]}};
    end
  end

  // A grant always refills the register, even when it is draining this
  // cycle. A drain without a grant only clears valid; data keeps its last
  // value so downstream logic sees a stable bus.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (|yumi) begin
      v_d    = 1'b1;
      data_d = sel_data;
    end else if (deq) begin
      v_d    = 1'b0;
    end
  end

  // Output register; reset drops whatever word was in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign bus_if.v_o    = v_q;
  assign bus_if.data_o = data_q;

`ifdef BSG_DFF_SHARE_TAG_EN
  logic [lg_els_lp-1:0] tag_q;
  logic [lg_els_lp-1:0] tag_d;

  // The tag follows the data register: loaded with the winner index on a
  // grant and held otherwise, including when valid drops.
  assign tag_d = (|yumi) ? grant : tag_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign bus_if.tag_o = tag_q;
`endif

  // Simulation checks: the consumer must not yumi an empty register, and the
  // arbiter's grant vector must be one-hot and agree with its grant index.
  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) bus_if.yumi_i |-> v_q
  );

  a_grant_consistent: assert property (
    @(posedge clk_i) disable iff (reset_i) (|yumi) |-> ($onehot(yumi) && yumi[grant])
  );

endmodule

// File: tb/tb_bsg_dff_share_rr.sv
// ----------------------------------------------------------------------------
// tb_bsg_dff_share_rr
//
// Purpose:
//   Self-checking bench for bsg_dff_share_rr (width_p=16, els_p=4). Directed
//   scenarios with literal expectations are followed by a long randomized run.
//   A transaction-level model (last-winner pointer, held word, valid flag)
//   predicts the outputs, and one compare process checks the DUT every cycle.
//
// Configuration: define BSG_DFF_SHARE_TAG_EN to also check tag_o.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bsg_dff_share_rr;
  import bsg_dff_share_pkg::*;

  localparam int tbWidth = 16;
  localparam int tbEls   = 4;

  logic clk_i;
  logic reset_i;

  bsg_dff_share_rr_if #(.width_p(tbWidth), .els_p(tbEls)) busIf ();

  bsg_dff_share_rr #(
    .width_p (tbWidth),
    .els_p   (tbEls)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus_if  (busIf)
  );

  // Free-running clock, 10 ns period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Requester-side shadow of what the bench is presenting.
  logic [tbEls-1:0] reqV;
  logic [15:0]      reqD [tbEls];

  // Reference model state: what the register holds after the last edge.
  int         mPtr;
  bit         mV;
  logic [15:0] mData;
  int         mTag;
  int         lastGrant;

  int checks = 0;
  int fails  = 0;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Copy the shadow requester state onto the bus.
  task automatic driveBus();
    busIf.v_i = reqV;
    for (int r = 0; r < tbEls; r++) begin
      busIf.data_i[r*tbWidth +: tbWidth] = reqD[r];
    end
  endtask

  // Drive one cycle of directed stimulus at the falling edge and let the
  // combinational outputs settle before returning.
  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] words, input logic yumi);
    @(negedge clk_i);
    reqV = v;
    for (int r = 0; r < tbEls; r++) begin
      reqD[r] = words[r*16 +: 16];
    end
    busIf.yumi_i = yumi;
    driveBus();
    #1;
  endtask

  // Reset contents of the model register.
  task automatic modelReset();
    mPtr      = tbEls - 1;
    mV        = 1'b0;
    mData     = 16'h0000;
    mTag      = 0;
    lastGrant = -1;
  endtask

  // Round-robin rule: first requesting index after the last winner.
  function automatic int pickWinner(input int ptr, input logic [3:0] req);
    for (int k = 1; k <= tbEls; k++) begin
      if (req[(ptr + k) % tbEls]) return (ptr + k) % tbEls;
    end
    return -1;
  endfunction

  // Asynchronous reset clears the model as soon as it is asserted.
  initial begin
    forever begin
      @(posedge reset_i);
      modelReset();
    end
  end

  // Compare process: inputs are driven at the falling edge, so two ns later
  // the outputs are settled. Check them against the model, then advance the
  // model to what the next rising edge must produce.
  initial begin
    int g;
    bit space;
    forever begin
      @(negedge clk_i);
      #2;
      if (reset_i) begin
        modelReset();
        checkOutput("cmp_yumi_rst", 32'(busIf.yumi_o), 32'd0);
        checkOutput("cmp_v_rst",    32'(busIf.v_o),    32'd0);
        checkOutput("cmp_data_rst", 32'(busIf.data_o), 32'd0);
      end else begin
        space = !mV || busIf.yumi_i;
        g = space ? pickWinner(mPtr, reqV) : -1;
        checkOutput("cmp_yumi", 32'(busIf.yumi_o), (g >= 0) ? (32'd1 << g) : 32'd0);
        checkOutput("cmp_v",    32'(busIf.v_o),    32'(mV));
        checkOutput("cmp_data", 32'(busIf.data_o), 32'(mData));
`ifdef BSG_DFF_SHARE_TAG_EN
        checkOutput("cmp_tag",  32'(busIf.tag_o),  32'(mTag));
`endif
        if (g >= 0) begin
          mV    = 1'b1;
          mData = reqD[g];
          mTag  = g;
          mPtr  = g;
        end else if (busIf.yumi_i && mV) begin
          mV = 1'b0;
        end
        lastGrant = g;
      end
    end
  end

  // Main stimulus: directed scenarios, then randomized traffic.
  initial begin
    reset_i      = 1'b0;
    busIf.yumi_i = 1'b0;
    for (int r = 0; r < tbEls; r++) begin
      reqV[r] = 1'b1;
      reqD[r] = 16'hA000 + 16'(r);
    end
    driveBus();

    // Scenario 1: reset asserted mid-cycle with requests pending.
    #3 reset_i = 1'b1;
    #1;
    checkOutput("s1_v_async",    32'(busIf.v_o),    32'd0);
    checkOutput("s1_data_async", 32'(busIf.data_o), 32'h0000);
    checkOutput("s1_yumi_async", 32'(busIf.yumi_o), 32'd0);
    @(negedge clk_i);
    #1;
    checkOutput("s1_yumi_held", 32'(busIf.yumi_o), 32'd0);

    // Scenario 2: everyone requesting, consumer always ready once valid.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      reset_i      = 1'b0;
      busIf.yumi_i = (c != 0);
      driveBus();
      #1;
      checkOutput("s2_yumi", 32'(busIf.yumi_o), 32'd1 << (c % 4));
      if (c == 0) begin
        checkOutput("s2_v0", 32'(busIf.v_o), 32'd0);
      end else begin
        checkOutput("s2_v",    32'(busIf.v_o),    32'd1);
        checkOutput("s2_data", 32'(busIf.data_o), 32'hA000 + 32'((c - 1) % 4));
`ifdef BSG_DFF_SHARE_TAG_EN
        checkOutput("s2_tag",  32'(busIf.tag_o),  32'((c - 1) % 4));
`endif
      end
    end

    // Scenario 3: backpressure holds the register, then a same-cycle swap.
    applyStimulus(4'b0100, {16'h0, 16'hC002, 16'h0, 16'h0}, 1'b0);
    checkOutput("s3_yumi_bp",  32'(busIf.yumi_o), 32'd0);
    checkOutput("s3_data_bp",  32'(busIf.data_o), 32'hA003);
    applyStimulus(4'b0100, {16'h0, 16'hC002, 16'h0, 16'h0}, 1'b0);
    checkOutput("s3_yumi_bp2", 32'(busIf.yumi_o), 32'd0);
    checkOutput("s3_data_bp2", 32'(busIf.data_o), 32'hA003);
    applyStimulus(4'b0100, {16'h0, 16'hC002, 16'h0, 16'h0}, 1'b1);
    checkOutput("s3_yumi_go",  32'(busIf.yumi_o), 32'b0100);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    checkOutput("s3_data_new", 32'(busIf.data_o), 32'hC002);
    checkOutput("s3_v_new",    32'(busIf.v_o),    32'd1);
    applyStimulus(4'b0000, 64'h0, 1'b0);
    checkOutput("s3_v_drain",  32'(busIf.v_o),    32'd0);

    // Scenario 4: pointer at 2, only 0 and 1 requesting.
    applyStimulus(4'b0011, {16'h0, 16'h0, 16'hD001, 16'hD000}, 1'b0);
    checkOutput("s4_yumi_a", 32'(busIf.yumi_o), 32'b0001);
    applyStimulus(4'b0011, {16'h0, 16'h0, 16'hD001, 16'hD010}, 1'b1);
    checkOutput("s4_yumi_b", 32'(busIf.yumi_o), 32'b0010);
    checkOutput("s4_data_b", 32'(busIf.data_o), 32'hD000);
    applyStimulus(4'b0011, {16'h0, 16'h0, 16'hD011, 16'hD010}, 1'b1);
    checkOutput("s4_yumi_c", 32'(busIf.yumi_o), 32'b0001);
    checkOutput("s4_data_c", 32'(busIf.data_o), 32'hD001);
    applyStimulus(4'b0010, {16'h0, 16'h0, 16'hD011, 16'h0}, 1'b1);
    checkOutput("s4_yumi_d", 32'(busIf.yumi_o), 32'b0010);
    checkOutput("s4_data_d", 32'(busIf.data_o), 32'hD010);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    checkOutput("s4_data_e", 32'(busIf.data_o), 32'hD011);
    applyStimulus(4'b0000, 64'h0, 1'b0);
    checkOutput("s4_v_f",    32'(busIf.v_o),    32'd0);

    // Scenario 5: single word from requester 3, then drain.
    applyStimulus(4'b1000, {16'hBEEF, 16'h0, 16'h0, 16'h0}, 1'b0);
    checkOutput("s5_yumi",   32'(busIf.yumi_o), 32'b1000);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    checkOutput("s5_v",      32'(busIf.v_o),    32'd1);
    checkOutput("s5_data",   32'(busIf.data_o), 32'hBEEF);
    applyStimulus(4'b0000, 64'h0, 1'b0);
    checkOutput("s5_v_fall", 32'(busIf.v_o),    32'd0);
    checkOutput("s5_hold",   32'(busIf.data_o), 32'hBEEF);
`ifdef BSG_DFF_SHARE_TAG_EN
    checkOutput("s5_tag",    32'(busIf.tag_o),  32'd3);
`endif

    // Randomized traffic: requesters hold until acknowledged, the consumer
    // yumis only a valid register, and a mid-cycle reset lands partway.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      if (cyc == 1503) reset_i = 1'b0;
      for (int r = 0; r < tbEls; r++) begin
        if (!reqV[r] || r == lastGrant) begin
          reqV[r] = (cyc < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
          reqD[r] = 16'($urandom);
        end
      end
      busIf.yumi_i = mV && ($urandom_range(0, 3) != 0);
      driveBus();
      if (cyc == 1500) begin
        #3 reset_i = 1'b1;
        #1;
        checkOutput("rnd_rst_v",    32'(busIf.v_o),    32'd0);
        checkOutput("rnd_rst_data", 32'(busIf.data_o), 32'h0000);
        checkOutput("rnd_rst_yumi", 32'(busIf.yumi_o), 32'd0);
      end
    end

    @(negedge clk_i);
    busIf.yumi_i = 1'b0;
    reqV = '0;
    driveBus();
    repeat (3) @(negedge clk_i);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
